// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter family: FSM states and width helpers.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  // Width of the binary owner index; a two-device bus still needs one select bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width of the hold counter, able to represent 0..MAX_HOLD.
  function automatic int cnt_width(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import bus_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int SEL_W   = sel_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W:0]     off;
  logic [SEL_W:0]     sum;

  // Rotate requests so bit 0 is the device at ptr, then find the lowest set bit.
  always_comb begin
    int unsigned idx;
    rot = '0;
    off = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      rot[i] = req[idx];
    end
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (rot[i-1]) off = (SEL_W+1)'(i - 1);
    end
  end

  // Map the rotated offset back to an absolute device index.
  always_comb begin
    sum = {1'b0, ptr} + off;
    if (sum >= (SEL_W+1)'(NUM_REQ)) sum = sum - (SEL_W+1)'(NUM_REQ);
    win = sum[SEL_W-1:0];
    any = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one dead cycle between owners and a per-grant hold limit.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int SEL_W    = sel_width(NUM_REQ),
  localparam int CNT_W    = cnt_width(MAX_HOLD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               bus_en,
  output logic               timeout
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("bus_arbiter: NUM_REQ must be >= 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be >= 1");
  end

  arb_state_t         state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               bus_en_nxt;
  logic               timeout_nxt;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_win;
  logic               owner_done;
  logic               owner_req;
  logic               expired;
  logic               release_now;
  logic [SEL_W-1:0]   ptr_after;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .win (pick_win)
  );

  // Owner-side release conditions; sel always names the current owner while granted.
  always_comb begin
    owner_done  = done[sel];
    owner_req   = req[sel];
    expired     = (cnt == CNT_W'(MAX_HOLD - 1));
    release_now = owner_done | ~owner_req | expired;
    ptr_after   = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
  end

  // Next-state and next-output logic; IDLE and TURN share the arbitration path.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    bus_en_nxt  = bus_en;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE, ST_TURN: begin
        if (pick_any) begin
          state_nxt  = ST_GRANT;
          gnt_nxt    = NUM_REQ'(1) << pick_win;
          sel_nxt    = pick_win;
          bus_en_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          state_nxt  = ST_IDLE;
          gnt_nxt    = '0;
          bus_en_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_nxt   = ST_TURN;
          gnt_nxt     = '0;
          bus_en_nxt  = 1'b0;
          ptr_nxt     = ptr_after;
          // Expiry only reports when the owner did not give up the bus itself.
          timeout_nxt = expired & owner_req & ~owner_done;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        gnt_nxt    = '0;
        bus_en_nxt = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      sel     <= '0;
      bus_en  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      sel     <= sel_nxt;
      bus_en  <= bus_en_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: two arbiter instances (4 dev/hold 8, 3 dev/hold 1) against an ownership model.
module tb_bus_arbiter;

  localparam int N0 = 4;
  localparam int H0 = 8;
  localparam int N1 = 3;
  localparam int H1 = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N0-1:0] req;
  logic [N0-1:0] done;

  logic [N0-1:0] gnt0;
  logic [1:0]    sel0;
  logic          bus_en0, timeout0;
  logic [N1-1:0] gnt1;
  logic [1:0]    sel1;
  logic          bus_en1, timeout1;

  logic [7:0] obs0, exp0;
  logic [6:0] obs1, exp1;

  int total = 0;
  int bad   = 0;

  // Ownership model per instance: owner (-1 none), cycles held, gap flag, rotation start, last owner.
  int m_n [2] = '{N0, N1};
  int m_h [2] = '{H0, H1};
  int m_owner [2];
  int m_held  [2];
  int m_gap   [2];
  int m_ptr   [2];
  int m_last  [2];
  int m_to    [2];

  always #5 clk = ~clk;

  assign obs0 = {gnt0, sel0, bus_en0, timeout0};
  assign obs1 = {gnt1, sel1, bus_en1, timeout1};

  bus_arbiter #(.NUM_REQ(N0), .MAX_HOLD(H0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt0), .sel(sel0), .bus_en(bus_en0), .timeout(timeout0)
  );

  bus_arbiter #(.NUM_REQ(N1), .MAX_HOLD(H1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req[N1-1:0]), .done(done[N1-1:0]),
    .gnt(gnt1), .sel(sel1), .bus_en(bus_en1), .timeout(timeout1)
  );

  function automatic int pick(input int u);
    for (int k = 0; k < m_n[u]; k++) begin
      int idx;
      idx = (m_ptr[u] + k) % m_n[u];
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1; m_held[u] = 0; m_gap[u] = 0;
      m_ptr[u] = 0; m_last[u] = 0; m_to[u] = 0;
    end
  endtask

  task automatic model_step(input int u);
    int o;
    m_to[u] = 0;
    if (m_gap[u] != 0) begin
      m_gap[u] = 0;
      m_owner[u] = pick(u);
      m_held[u] = 1;
    end else if (m_owner[u] >= 0) begin
      o = m_owner[u];
      if (done[o] || !req[o] || m_held[u] == m_h[u]) begin
        m_to[u] = (m_held[u] == m_h[u] && !done[o] && req[o]) ? 1 : 0;
        m_last[u] = o;
        m_ptr[u] = (o + 1) % m_n[u];
        m_owner[u] = -1;
        m_gap[u] = 1;
      end else begin
        m_held[u]++;
      end
    end else begin
      o = pick(u);
      if (o >= 0) begin
        m_owner[u] = o;
        m_held[u] = 1;
      end
    end
  endtask

  task automatic compute_exp();
    exp0 = {(m_owner[0] >= 0) ? 4'(1 << m_owner[0]) : 4'b0,
            2'((m_owner[0] >= 0) ? m_owner[0] : m_last[0]),
            m_owner[0] >= 0, m_to[0] != 0};
    exp1 = {(m_owner[1] >= 0) ? 3'(1 << m_owner[1]) : 3'b0,
            2'((m_owner[1] >= 0) ? m_owner[1] : m_last[1]),
            m_owner[1] >= 0, m_to[1] != 0};
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int u = 0; u < 2; u++) model_step(u);
    #1;
    compute_exp();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; done = '0;
    #1;
    model_reset();
    compute_exp();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = '0;
    model_reset();
    tick();
    tick();
    total++; if (gnt0 !== 4'b0000 || sel0 !== 2'd0 || bus_en0 !== 1'b0 || timeout0 !== 1'b0) begin
      bad++; $display("FAIL reset_state got gnt=%b sel=%0d en=%b to=%b want 0000/0/0/0", gnt0, sel0, bus_en0, timeout0); end
    total++; if (obs1 !== exp1) begin bad++; $display("FAIL reset_d1 got %b want %b", obs1, exp1); end
    rst_n = 1'b1;
    tick();
    total++; if (gnt0 !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got %b want 0001", gnt0); end
    total++; if (obs0 !== exp0) begin bad++; $display("FAIL reset_d0 got %b want %b", obs0, exp0); end
    total++; if (obs1 !== exp1) begin bad++; $display("FAIL reset_d1_post got %b want %b", obs1, exp1); end
  endtask

  task automatic test_rotation();
    logic [3:0] seen [5];
    logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prev = '0;
    int n_seen = 0;
    apply_reset();
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      tick();
      total++; if (obs0 !== exp0) begin bad++; $display("FAIL rotation_d0 cyc=%0d got %b want %b", c, obs0, exp0); end
      total++; if (obs1 !== exp1) begin bad++; $display("FAIL rotation_d1 cyc=%0d got %b want %b", c, obs1, exp1); end
      if (gnt0 != 4'b0000 && gnt0 != prev && n_seen < 5) begin seen[n_seen] = gnt0; n_seen++; end
      prev = gnt0;
      done = (bus_en0 && m_held[0] == 2) ? gnt0 : 4'b0000;
    end
    done = '0;
    total++; if (n_seen !== 5) begin bad++; $display("FAIL rotation_count got %0d want 5", n_seen); end
    for (int i = 0; i < n_seen; i++) begin
      total++; if (seen[i] !== want[i]) begin bad++; $display("FAIL rotation_order[%0d] got %b want %b", i, seen[i], want[i]); end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++; if (gnt0 !== 4'b0100 || timeout0 !== 1'b0) begin
        bad++; $display("FAIL timeout_hold cyc=%0d got gnt=%b to=%b want 0100/0", c, gnt0, timeout0); end
      total++; if (obs1 !== exp1) begin bad++; $display("FAIL timeout_d1 cyc=%0d got %b want %b", c, obs1, exp1); end
    end
    tick();
    total++; if (gnt0 !== 4'b0000 || timeout0 !== 1'b1 || sel0 !== 2'd2) begin
      bad++; $display("FAIL timeout_turn got gnt=%b to=%b sel=%0d want 0000/1/2", gnt0, timeout0, sel0); end
    tick();
    total++; if (gnt0 !== 4'b0100 || timeout0 !== 1'b0) begin
      bad++; $display("FAIL timeout_regrant got gnt=%b to=%b want 0100/0", gnt0, timeout0); end
    total++; if (obs0 !== exp0) begin bad++; $display("FAIL timeout_d0 got %b want %b", obs0, exp0); end
  endtask

  task automatic test_collision();
    apply_reset();
    req = 4'b0010;
    for (int c = 0; c < 3; c++) tick();
    done = 4'b1000;
    tick();
    done = '0;
    total++; if (gnt0 !== 4'b0010 || bus_en0 !== 1'b1) begin
      bad++; $display("FAIL collision_foreign_done got gnt=%b en=%b want 0010/1", gnt0, bus_en0); end
    for (int c = 0; c < 4; c++) tick();
    total++; if (obs0 !== exp0) begin bad++; $display("FAIL collision_d0_pre got %b want %b", obs0, exp0); end
    done = 4'b0010;
    tick();
    done = '0;
    total++; if (gnt0 !== 4'b0000 || timeout0 !== 1'b0) begin
      bad++; $display("FAIL collision_done_vs_expiry got gnt=%b to=%b want 0000/0", gnt0, timeout0); end
    total++; if (obs1 !== exp1) begin bad++; $display("FAIL collision_d1 got %b want %b", obs1, exp1); end
  endtask

  task automatic test_wrap();
    apply_reset();
    req = 4'b1000;
    tick();
    total++; if (gnt0 !== 4'b1000) begin bad++; $display("FAIL wrap_owner3 got %b want 1000", gnt0); end
    req = 4'b1010; done = 4'b1000;
    tick();
    done = '0;
    total++; if (gnt0 !== 4'b0000 || sel0 !== 2'd3) begin
      bad++; $display("FAIL wrap_turn got gnt=%b sel=%0d want 0000/3", gnt0, sel0); end
    tick();
    total++; if (gnt0 !== 4'b0010 || sel0 !== 2'd1) begin
      bad++; $display("FAIL wrap_skip got gnt=%b sel=%0d want 0010/1", gnt0, sel0); end
    total++; if (obs0 !== exp0) begin bad++; $display("FAIL wrap_d0 got %b want %b", obs0, exp0); end
    total++; if (obs1 !== exp1) begin bad++; $display("FAIL wrap_d1 got %b want %b", obs1, exp1); end
  endtask

  task automatic test_midreset();
    apply_reset();
    req = 4'b0010;
    tick();
    total++; if (gnt0 !== 4'b0010) begin bad++; $display("FAIL midreset_pre got %b want 0010", gnt0); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (gnt0 !== 4'b0000 || bus_en0 !== 1'b0) begin
      bad++; $display("FAIL midreset_async got gnt=%b en=%b want 0000/0", gnt0, bus_en0); end
    model_reset();
    req = 4'b0011;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (gnt0 !== 4'b0001) begin bad++; $display("FAIL midreset_dev0_first got %b want 0001", gnt0); end
    total++; if (obs1 !== exp1) begin bad++; $display("FAIL midreset_d1 got %b want %b", obs1, exp1); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N0; i++) if ($urandom_range(9) == 0) req[i] = ~req[i];
      if ($urandom_range(5) == 0) done = gnt0;
      else if ($urandom_range(7) == 0) done = 4'(1 << $urandom_range(3));
      else done = '0;
      tick();
      total++; if (obs0 !== exp0) begin bad++; $display("FAIL random_d0 cyc=%0d got %b want %b", c, obs0, exp0); end
      total++; if (obs1 !== exp1) begin bad++; $display("FAIL random_d1 cyc=%0d got %b want %b", c, obs1, exp1); end
      total++; if (!$onehot0(gnt0) || bus_en0 !== (|gnt0) || (bus_en0 && gnt0[sel0] !== 1'b1)) begin
        bad++; $display("FAIL random_invariant cyc=%0d got gnt=%b sel=%0d en=%b want onehot0/en=|gnt/gnt[sel]", c, gnt0, sel0, bus_en0); end
    end
    done = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_timeout();
    test_collision();
    test_wrap();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
